// File: rtl/wfd_regs_pkg.sv
// ---------------------------------------------------------------------------
// wfd_regs_pkg
// Shared definitions for the Wishbone register bank: word-register index map,
// default register count / board ID, and a byte-enable expansion helper.
// ---------------------------------------------------------------------------
package wfd_regs_pkg;

    localparam int          NREGS    = 16;
    localparam logic [31:0] BOARD_ID = 32'h0125_0001;

    // Word register map (index = wb_adr_i[3:0])
    localparam logic [3:0] REG_ID     = 4'd0;
    localparam logic [3:0] REG_CSR    = 4'd1;
    localparam logic [3:0] REG_PULSE  = 4'd2;
    localparam logic [3:0] REG_CNT_LO = 4'd3;
    localparam logic [3:0] REG_CNT_HI = 4'd4;
    localparam logic [3:0] REG_STAT0  = 4'd5;
    localparam logic [3:0] REG_STAT1  = 4'd6;
    localparam logic [3:0] REG_STAT2  = 4'd7;
    localparam logic [3:0] REG_CFG0   = 4'd8;
    localparam logic [3:0] REG_CFG1   = 4'd9;
    localparam logic [3:0] REG_CFG2   = 4'd10;
    localparam logic [3:0] REG_CFG3   = 4'd11;
    localparam logic [3:0] REG_CFG4   = 4'd12;
    localparam logic [3:0] REG_CFG5   = 4'd13;
    localparam logic [3:0] REG_CFG6   = 4'd14;
    localparam logic [3:0] REG_CFG7   = 4'd15;

    localparam int NCFG  = 8;
    localparam int NSTAT = 3;

    // Expand 4 byte enables into a 32-bit bit mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/wb_uptime_cnt.sv
// ---------------------------------------------------------------------------
// wb_uptime_cnt
// Free-running 48-bit uptime counter with a 16-bit shadow of the upper bits.
// The shadow is captured when latch_i is high so a LO read followed by a HI
// read always returns a coherent 48-bit value, even across a carry.
// Ports:
//   clk_i    clock
//   rst_i    asynchronous active-high reset (counter -> INIT, shadow -> 0)
//   latch_i  capture cnt[47:32] into the shadow at this clock edge
//   cnt_o    current counter value
//   hi_o     shadowed upper 16 bits
// ---------------------------------------------------------------------------
module wb_uptime_cnt #(
    parameter logic [47:0] INIT = 48'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        latch_i,
    output logic [47:0] cnt_o,
    output logic [15:0] hi_o
);

    logic [47:0] cnt_q, cnt_d;
    logic [15:0] hi_q, hi_d;

    always_comb begin
        cnt_d = cnt_q + 48'd1;   // wraps 2^48-1 -> 0 naturally
        hi_d  = latch_i ? cnt_q[47:32] : hi_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= INIT;
            hi_q  <= 16'h0;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
        end
    end

    assign cnt_o = cnt_q;
    assign hi_o  = hi_q;

endmodule

// File: rtl/wb_reg_bank.sv
// ---------------------------------------------------------------------------
// wb_reg_bank
// Pipelined Wishbone B4 slave register bank: board ID, CSR, write-1 pulse
// register, 48-bit uptime counter (LO + shadowed HI), three status inputs and
// eight read/write config words. Never stalls; every request is terminated
// with exactly one of ack/err in the following cycle.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   wb_cyc_i/stb_i/we_i   Wishbone request qualifiers
//   wb_adr_i, wb_sel_i    word address, byte enables
//   wb_dat_i, wb_dat_o    write data, read data (valid with ack)
//   wb_ack_o, wb_err_o    terminations; wb_rty_o, wb_stall_o tied 0
//   csr_o                 CSR contents
//   pulse_o               one-cycle pulses from PULSE register writes
//   status_i              status words for regs 5..7 (reg5 = [31:0])
//   cfg_o                 config words regs 8..15 (reg8 = [31:0])
// UPTIME_INIT sets the counter reset value (0 in normal use).
// ---------------------------------------------------------------------------
module wb_reg_bank #(
    parameter int          NREGS       = wfd_regs_pkg::NREGS,
    parameter int          ADR_W       = 30,
    parameter logic [31:0] BOARD_ID    = wfd_regs_pkg::BOARD_ID,
    parameter logic [31:0] CTRL_RST    = 32'h0000_0000,
    parameter logic [47:0] UPTIME_INIT = 48'h0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [ADR_W-1:0]    wb_adr_i,
    input  logic [3:0]          wb_sel_i,
    input  logic [31:0]         wb_dat_i,
    output logic [31:0]         wb_dat_o,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic                wb_rty_o,
    output logic                wb_stall_o,
    output logic [31:0]         csr_o,
    output logic [31:0]         pulse_o,
    input  logic [95:0]         status_i,
    output logic [255:0]        cfg_o
);
    import wfd_regs_pkg::*;

    localparam int IDX_W = $clog2(NREGS);

    logic             req;
    logic [3:0]       idx;
    logic             adr_bad;
    logic             is_ro;
    logic             wr_ok;
    logic             rd_ok;
    logic             cnt_latch;
    logic [31:0]      mask;
    logic [31:0]      rd_data;

    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [31:0]      dat_q, dat_d;
    logic [31:0]      csr_q, csr_d;
    logic [31:0]      pulse_q, pulse_d;
    logic [31:0]      cfg_q [NCFG];
    logic [31:0]      cfg_d [NCFG];

    logic [47:0]      cnt;
    logic [15:0]      cnt_hi;

    // ---------------- request decode ----------------
    always_comb begin
        req     = wb_cyc_i & wb_stb_i;
        idx     = wb_adr_i[IDX_W-1:0];
        adr_bad = |wb_adr_i[ADR_W-1:IDX_W];
        is_ro   = (idx == REG_ID)     || (idx == REG_CNT_LO) || (idx == REG_CNT_HI) ||
                  (idx == REG_STAT0)  || (idx == REG_STAT1)  || (idx == REG_STAT2);
        err_d   = req & (adr_bad | (wb_we_i & is_ro));
        ack_d   = req & ~err_d;
        wr_ok   = ack_d & wb_we_i;
        rd_ok   = ack_d & ~wb_we_i;
        mask    = byte_mask(wb_sel_i);
        // Reading LO freezes the matching HI half for the following HI read.
        cnt_latch = rd_ok && (idx == REG_CNT_LO);
    end

    // ---------------- read mux ----------------
    always_comb begin
        rd_data = 32'h0;
        case (idx)
            REG_ID:     rd_data = BOARD_ID;
            REG_CSR:    rd_data = csr_q;
            REG_PULSE:  rd_data = 32'h0;
            REG_CNT_LO: rd_data = cnt[31:0];
            REG_CNT_HI: rd_data = {16'h0, cnt_hi};
            REG_STAT0:  rd_data = status_i[31:0];
            REG_STAT1:  rd_data = status_i[63:32];
            REG_STAT2:  rd_data = status_i[95:64];
            default:    rd_data = cfg_q[idx[2:0]];   // 8..15
        endcase
    end

    // ---------------- next-state ----------------
    always_comb begin
        // Read data updates only on an accepted request; idle cycles hold it.
        dat_d   = req ? (rd_ok ? rd_data : 32'h0) : dat_q;
        pulse_d = (wr_ok && (idx == REG_PULSE)) ? (wb_dat_i & mask) : 32'h0;
        csr_d   = (wr_ok && (idx == REG_CSR)) ? ((csr_q & ~mask) | (wb_dat_i & mask)) : csr_q;
        for (int i = 0; i < NCFG; i++) begin
            cfg_d[i] = cfg_q[i];
            if (wr_ok && (idx == (REG_CFG0 + 4'(i)))) begin
                cfg_d[i] = (cfg_q[i] & ~mask) | (wb_dat_i & mask);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= 32'h0;
            csr_q   <= CTRL_RST;
            pulse_q <= 32'h0;
            for (int i = 0; i < NCFG; i++) begin
                cfg_q[i] <= 32'h0;
            end
        end else begin
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            csr_q   <= csr_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < NCFG; i++) begin
                cfg_q[i] <= cfg_d[i];
            end
        end
    end

    // ---------------- uptime counter ----------------
    wb_uptime_cnt #(
        .INIT (UPTIME_INIT)
    ) u_uptime (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .latch_i (cnt_latch),
        .cnt_o   (cnt),
        .hi_o    (cnt_hi)
    );

    // ---------------- outputs ----------------
    assign wb_dat_o   = dat_q;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign wb_rty_o   = 1'b0;
    assign wb_stall_o = 1'b0;
    assign csr_o      = csr_q;
    assign pulse_o    = pulse_q;

    generate
        for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg_out
            assign cfg_o[32*gi +: 32] = cfg_q[gi];
        end
    endgenerate

endmodule
